// File: rtl/data_frame_pkg.sv
// rtl/data_frame_pkg.sv - framing constants shared by the data-frame generator and parser
// Header: FF | ch[55:52] | ts_lo[51:28] | pad[27:len_w] | len. Footer: F | base | 111 | thr | ts_hi | 0F.
package data_frame_pkg;

  localparam logic [7:0] HEADER_ID = 8'hFF;
  localparam logic [7:0] FOOTER_ID = 8'h0F;

  localparam int HDR_ID_MSB  = 63;
  localparam int HDR_ID_LSB  = 56;
  localparam int HDR_CH_MSB  = 55;
  localparam int HDR_CH_LSB  = 52;
  localparam int HDR_TS_MSB  = 51;
  localparam int HDR_TS_LSB  = 28;
  localparam int HDR_PAD_MSB = 27;

  localparam int FTR_FILL_MSB     = 63;
  localparam int FTR_FILL_LSB     = 60;
  localparam int FTR_BASE_MSB     = 59;
  localparam int FTR_BASE_LSB     = 48;
  localparam int FTR_THR_FILL_MSB = 47;
  localparam int FTR_THR_FILL_LSB = 45;
  localparam int FTR_THR_MSB      = 44;
  localparam int FTR_THR_LSB      = 32;
  localparam int FTR_TS_MSB       = 31;
  localparam int FTR_TS_LSB       = 8;
  localparam int FTR_ID_MSB       = 7;
  localparam int FTR_ID_LSB       = 0;

  // Padding above the 12-bit baseline and 13-bit threshold is driven all-ones by the generator.
  localparam logic [3:0] BASELINE_FILL  = 4'hF;
  localparam logic [2:0] THRESHOLD_FILL = 3'b111;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_DATA   = 2'd1,
    ST_FOOTER = 2'd2
  } state_t;

endpackage

// File: rtl/frame_stat_counter.sv
// rtl/frame_stat_counter.sv - saturating event counter with increment enable
module frame_stat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/data_frame_parser.sv
// rtl/data_frame_parser.sv - validates header/footer framing, forwards payload, publishes frame info
module data_frame_parser
  import data_frame_pkg::*;
#(
  parameter int DATA_WIDTH           = 64,
  parameter int MAX_FRAME_LENGTH     = 400,
  parameter int FRAME_LEN_WIDTH      = 10,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int ERR_CNT_WIDTH        = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          iVALID,
  input  logic [DATA_WIDTH-1:0]         DIN,
  output logic                          oREADY,
  output logic                          oVALID,
  output logic [DATA_WIDTH-1:0]         DOUT,
  output logic                          DOUT_LAST,
  input  logic                          iREADY,
  output logic                          INFO_VALID,
  output logic [3:0]                    INFO_CH_ID,
  output logic [47:0]                   INFO_TIME_STAMP,
  output logic [ADC_RESOLUTION_WIDTH-1:0] INFO_BASELINE,
  output logic [ADC_RESOLUTION_WIDTH:0]   INFO_THRESHOLD,
  output logic [FRAME_LEN_WIDTH-1:0]    INFO_FRAME_LEN,
  output logic                          ERR_HEADER,
  output logic                          ERR_LENGTH,
  output logic                          ERR_FOOTER,
  output logic [ERR_CNT_WIDTH-1:0]      FRAME_CNT,
  output logic [ERR_CNT_WIDTH-1:0]      ERR_CNT
);

  state_t                     state;
  logic [FRAME_LEN_WIDTH-1:0] remaining;
  logic [FRAME_LEN_WIDTH-1:0] hdr_len;
  logic [3:0]                 hdr_ch;
  logic [23:0]                hdr_ts;

  logic [FRAME_LEN_WIDTH-1:0] din_len;
  logic hdr_id_ok, hdr_pad_ok, len_legal, ftr_ok;
  logic in_fire, data_fire, last_word;
  logic good_hdr, bad_pad, bad_len, good_ftr, bad_ftr;

  assign din_len    = DIN[FRAME_LEN_WIDTH-1:0];
  assign hdr_id_ok  = (DIN[HDR_ID_MSB:HDR_ID_LSB] == HEADER_ID);
  assign hdr_pad_ok = (DIN[HDR_PAD_MSB:FRAME_LEN_WIDTH] == '0);
  assign len_legal  = (din_len != '0) && !din_len[0] &&
                      (din_len <= FRAME_LEN_WIDTH'(MAX_FRAME_LENGTH));
  assign ftr_ok     = (DIN[FTR_ID_MSB:FTR_ID_LSB] == FOOTER_ID) &&
                      (DIN[FTR_FILL_MSB:FTR_FILL_LSB] == BASELINE_FILL) &&
                      (DIN[FTR_THR_FILL_MSB:FTR_THR_FILL_LSB] == THRESHOLD_FILL);

  // Only the payload phase is throttled by the output register; header/footer words never stall.
  assign oREADY    = ~RESET & ((state == ST_DATA) ? (~oVALID | iREADY) : 1'b1);
  assign in_fire   = iVALID & oREADY;
  assign data_fire = in_fire & (state == ST_DATA);
  assign last_word = (remaining == FRAME_LEN_WIDTH'(1));

  // Pad errors take priority so at most one error pulse fires per word.
  assign good_hdr = in_fire & (state == ST_HUNT) & hdr_id_ok & hdr_pad_ok & len_legal;
  assign bad_pad  = in_fire & (state == ST_HUNT) & hdr_id_ok & ~hdr_pad_ok;
  assign bad_len  = in_fire & (state == ST_HUNT) & hdr_id_ok & hdr_pad_ok & ~len_legal;
  assign good_ftr = in_fire & (state == ST_FOOTER) & ftr_ok;
  assign bad_ftr  = in_fire & (state == ST_FOOTER) & ~ftr_ok;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= ST_HUNT;
      remaining       <= '0;
      hdr_len         <= '0;
      hdr_ch          <= '0;
      hdr_ts          <= '0;
      oVALID          <= 1'b0;
      DOUT            <= '0;
      DOUT_LAST       <= 1'b0;
      INFO_VALID      <= 1'b0;
      INFO_CH_ID      <= '0;
      INFO_TIME_STAMP <= '0;
      INFO_BASELINE   <= '0;
      INFO_THRESHOLD  <= '0;
      INFO_FRAME_LEN  <= '0;
      ERR_HEADER      <= 1'b0;
      ERR_LENGTH      <= 1'b0;
      ERR_FOOTER      <= 1'b0;
    end else begin
      INFO_VALID <= good_ftr;
      ERR_HEADER <= bad_pad;
      ERR_LENGTH <= bad_len;
      ERR_FOOTER <= bad_ftr;

      // The output register drains in every state so a held last word can leave after DATA.
      if (data_fire) begin
        oVALID    <= 1'b1;
        DOUT      <= DIN;
        DOUT_LAST <= last_word;
      end else if (iREADY) begin
        oVALID    <= 1'b0;
        DOUT_LAST <= 1'b0;
      end

      case (state)
        ST_HUNT: begin
          if (good_hdr) begin
            hdr_ch    <= DIN[HDR_CH_MSB:HDR_CH_LSB];
            hdr_ts    <= DIN[HDR_TS_MSB:HDR_TS_LSB];
            hdr_len   <= din_len;
            remaining <= din_len;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_fire) begin
            remaining <= remaining - FRAME_LEN_WIDTH'(1);
            if (last_word) begin
              state <= ST_FOOTER;
            end
          end
        end
        ST_FOOTER: begin
          if (in_fire) begin
            state <= ST_HUNT;
            if (ftr_ok) begin
              INFO_CH_ID      <= hdr_ch;
              INFO_TIME_STAMP <= {DIN[FTR_TS_MSB:FTR_TS_LSB], hdr_ts};
              INFO_BASELINE   <= DIN[FTR_BASE_MSB:FTR_BASE_LSB];
              INFO_THRESHOLD  <= DIN[FTR_THR_MSB:FTR_THR_LSB];
              INFO_FRAME_LEN  <= hdr_len;
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  frame_stat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_frame_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .inc   (good_ftr),
    .count (FRAME_CNT)
  );

  frame_stat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .inc   (bad_pad | bad_len | bad_ftr),
    .count (ERR_CNT)
  );

endmodule

// File: tb/tb_data_frame_parser.sv
// tb/tb_data_frame_parser.sv - self-checking bench for data_frame_parser
module tb_data_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid;
  logic [63:0] din;
  logic        oready;
  logic        ovalid;
  logic [63:0] dout;
  logic        dout_last;
  logic        iready;
  logic        info_valid;
  logic [3:0]  info_ch;
  logic [47:0] info_ts;
  logic [11:0] info_base;
  logic [12:0] info_thr;
  logic [9:0]  info_len;
  logic        err_header, err_length, err_footer;
  logic [15:0] frame_cnt, err_cnt;

  data_frame_parser dut (
    .CLK(clk), .RESET(rst), .iVALID(ivalid), .DIN(din), .oREADY(oready),
    .oVALID(ovalid), .DOUT(dout), .DOUT_LAST(dout_last), .iREADY(iready),
    .INFO_VALID(info_valid), .INFO_CH_ID(info_ch), .INFO_TIME_STAMP(info_ts),
    .INFO_BASELINE(info_base), .INFO_THRESHOLD(info_thr), .INFO_FRAME_LEN(info_len),
    .ERR_HEADER(err_header), .ERR_LENGTH(err_length), .ERR_FOOTER(err_footer),
    .FRAME_CNT(frame_cnt), .ERR_CNT(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: a word either belongs to the current frame's payload,
  // is the awaited footer, or is examined as a candidate header.
  int          need = 0;
  bit          want_ftr = 0;
  logic [63:0] cur_hdr;
  int          m_frames = 0, m_errs = 0;
  bit          e_info, e_eh, e_el, e_ef, e_ov;
  logic [3:0]  e_ch;
  logic [47:0] e_ts;
  logic [11:0] e_base;
  logic [12:0] e_thr;
  logic [9:0]  e_len;
  logic [64:0] pq[$];
  logic [64:0] lq[$];
  int          n_info = 0, n_eh = 0, n_el = 0, n_ef = 0;
  logic [3:0]  cap_ch;
  logic [47:0] cap_ts;
  logic [11:0] cap_base;
  logic [12:0] cap_thr;
  logic [9:0]  cap_len;
  bit          bp = 0;

  task automatic model_word(input logic [63:0] w);
    int len;
    if (want_ftr) begin
      want_ftr = 0;
      if (w[7:0] == 8'h0F && w[63:60] == 4'hF && w[47:45] == 3'b111) begin
        e_info = 1; m_frames++;
        e_ch = cur_hdr[55:52];
        e_ts = {w[31:8], cur_hdr[51:28]};
        e_base = w[59:48];
        e_thr = w[44:32];
        e_len = cur_hdr[9:0];
      end else begin
        e_ef = 1; m_errs++;
      end
    end else if (need > 0) begin
      pq.push_back({(need == 1), w});
      e_ov = 1;
      need--;
      if (need == 0) want_ftr = 1;
    end else if (w[63:56] == 8'hFF) begin
      len = int'(w[9:0]);
      if (w[27:10] != 0) begin
        e_eh = 1; m_errs++;
      end else if (len == 0 || (len % 2) != 0 || len > 400) begin
        e_el = 1; m_errs++;
      end else begin
        need = len; cur_hdr = w;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_oready", oready, 0);
      chk("rst_out", {dout_last, ovalid}, 0);
      chk("rst_dout", dout, 0);
      chk("rst_info", {info_valid, info_ch, info_base, info_thr, info_len}, 0);
      chk("rst_ts", info_ts, 0);
      chk("rst_err", {err_header, err_length, err_footer}, 0);
      chk("rst_cnt", {frame_cnt, err_cnt}, 0);
      need = 0; want_ftr = 0; m_frames = 0; m_errs = 0;
      e_info = 0; e_eh = 0; e_el = 0; e_ef = 0; e_ov = 0;
      pq.delete();
    end else begin
      chk("info_valid", info_valid, e_info);
      if (e_info && info_valid) begin
        chk("info_ch", info_ch, e_ch);
        chk("info_ts", info_ts, e_ts);
        chk("info_base", info_base, e_base);
        chk("info_thr", info_thr, e_thr);
        chk("info_len", info_len, e_len);
      end
      if (info_valid) begin
        n_info++; cap_ch = info_ch; cap_ts = info_ts; cap_base = info_base;
        cap_thr = info_thr; cap_len = info_len;
      end
      chk("err_header", err_header, e_eh);
      chk("err_length", err_length, e_el);
      chk("err_footer", err_footer, e_ef);
      n_eh += int'(err_header); n_el += int'(err_length); n_ef += int'(err_footer);
      chk("frame_cnt", frame_cnt, (m_frames > 65535) ? 65535 : m_frames);
      chk("err_cnt", err_cnt, (m_errs > 65535) ? 65535 : m_errs);
      if (e_ov) chk("payload_latency", ovalid, 1);
      if (need > 0) chk("oready_data", oready, (!ovalid || iready));
      else chk("oready_open", oready, 1);
      if (ovalid && iready) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout_extra: got %h last %b expected no word", dout, dout_last);
        end else begin
          logic [64:0] e;
          e = pq.pop_front();
          chk("dout", dout, e[63:0]);
          chk("dout_last", dout_last, e[64]);
        end
        lq.push_back({dout_last, dout});
      end
      e_info = 0; e_eh = 0; e_el = 0; e_ef = 0; e_ov = 0;
      if (ivalid && oready) model_word(din);
    end
  end

  initial begin
    iready = 1'b1;
    forever begin
      @(posedge clk); #1;
      iready = bp ? ~iready : 1'b1;
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [3:0] ch, input logic [23:0] ts, input logic [9:0] len);
    return {8'hFF, ch, ts, 18'h0, len};
  endfunction

  function automatic logic [63:0] mk_ftr(input logic [11:0] base, input logic [12:0] thr, input logic [23:0] ts);
    return {4'hF, base, 3'b111, thr, ts, 8'h0F};
  endfunction

  task automatic send(input logic [63:0] w);
    int n = 0;
    din = w; ivalid = 1'b1;
    @(negedge clk);
    while (!oready && n < 100) begin n++; @(negedge clk); end
    if (!oready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got oREADY=0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic good_frame(input logic [3:0] ch, input logic [9:0] len);
    send(mk_hdr(ch, 24'hC0FFEE, len));
    for (int i = 0; i < int'(len); i++) send(64'hD000 + 64'(i));
    send(mk_ftr(12'h5A5, 13'h1BCD, 24'h0BEEF0));
  endtask

  initial begin
    logic [63:0] g;
    rst = 1'b1; ivalid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(64'hFF31234560000002); send(64'hA); send(64'hB); send(64'hFABCE1236543210F);
    idle(4);
    chk("f1_words", lq.size(), 2);
    chk("f1_w0", lq[0], {1'b0, 64'hA});
    chk("f1_w1", lq[1], {1'b1, 64'hB});
    chk("f1_ch", cap_ch, 4'h3);
    chk("f1_ts", cap_ts, 48'h654321123456);
    chk("f1_base", cap_base, 12'hABC);
    chk("f1_thr", cap_thr, 13'h0123);
    chk("f1_len", cap_len, 10'd2);
    chk("f1_fcnt", frame_cnt, 1);

    lq.delete(); bp = 1;
    send(mk_hdr(4'h5, 24'h000111, 10'd4));
    for (int i = 1; i <= 4; i++) send(64'h1100 + 64'(i));
    send(mk_ftr(12'h123, 13'h0456, 24'h000222));
    idle(6); bp = 0; idle(2);
    chk("bp_words", lq.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_order", lq[i], {(i == 3), 64'h1101 + 64'(i)});
    chk("bp_ts", cap_ts, 48'h000222000111);
    chk("bp_fcnt", frame_cnt, 2);

    lq.delete();
    send(mk_hdr(4'h1, 24'h0, 10'd2)); send(64'hC); send(64'hD); send(64'h0);
    idle(3);
    chk("bf_words", lq.size(), 2);
    chk("bf_errcnt", err_cnt, 1);
    chk("bf_pulses", n_ef, 1);
    chk("bf_no_info", n_info, 2);
    good_frame(4'h7, 10'd2); idle(3);
    chk("bf_recover", frame_cnt, 3);

    lq.delete();
    send(mk_hdr(4'h2, 24'h0, 10'd0));   send(64'h1234); send(64'h2);
    send(mk_hdr(4'h2, 24'h0, 10'd3));   send(64'h1234); send(64'h2);
    send(mk_hdr(4'h2, 24'h0, 10'd401)); send(64'h1234); send(64'h2);
    idle(2);
    chk("il_pulses", n_el, 3);
    chk("il_errcnt", err_cnt, 4);
    chk("il_dropped", lq.size(), 0);
    good_frame(4'h9, 10'd400); idle(3);
    chk("il_recover", frame_cnt, 4);
    chk("il_maxlen", cap_len, 10'd400);

    lq.delete();
    for (int i = 0; i < 5; i++) begin
      g = {$urandom, $urandom};
      if (g[63:56] == 8'hFF) g[63:56] = 8'h00;
      send(g);
    end
    idle(2);
    chk("gb_no_err", err_cnt, 4);
    chk("gb_dropped", lq.size(), 0);
    chk("gb_hdr_pulses", n_eh, 0);
    good_frame(4'hB, 10'd4); idle(3);
    chk("gb_recover", frame_cnt, 5);
    chk("gb_ch", cap_ch, 4'hB);

    send(mk_hdr(4'h4, 24'h0, 10'd4)); send(64'h77);
    rst = 1'b1; #1;
    chk("mr_out", {ovalid, dout_last}, 0);
    chk("mr_dout", dout, 0);
    chk("mr_cnt", frame_cnt, 0);
    chk("mr_oready", oready, 0);
    idle(3); rst = 1'b0;
    good_frame(4'hE, 10'd4); idle(3);
    chk("mr_fcnt", frame_cnt, 1);
    chk("mr_ch", cap_ch, 4'hE);
    chk("mr_ts", cap_ts, 48'h0BEEF0C0FFEE);

    idle(2);
    chk("end_queue_empty", pq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule

// File: doc/data_frame_parser.md
Name: data_frame_parser

Overview:
- Receive end of the channel data-frame stream.
- Accepts the 64-bit word stream (header, N payload words, footer) produced by the per-channel frame generator on the read-clock side.
- Validates the framing, strips header and footer, and forwards the payload words with a last-word marker.
- Publishes the decoded per-frame info (channel, 48-bit timestamp, baseline, threshold, length) once the footer checks out. Sits between the frame generator output and the readout/DMA packer.

Parameters:
- DATA_WIDTH, 64, stream word width; header and footer are each one word.
- MAX_FRAME_LENGTH, 400, maximum payload words per frame.
- FRAME_LEN_WIDTH, 10, width of the header length field, header bits [9:0].
- ADC_RESOLUTION_WIDTH, 12, baseline width; threshold width is this plus 1.
- ERR_CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  asynchronous, active-high.
- iVALID  in  1  upstream word valid.
- DIN  in  DATA_WIDTH  upstream word.
- oREADY  out  1  upstream ready.
- oVALID  out  1  payload word valid.
- DOUT  out  DATA_WIDTH  payload word.
- DOUT_LAST  out  1  marks the last payload word of a frame.
- iREADY  in  1  downstream ready.
- INFO_VALID  out  1  one-cycle pulse; INFO_* fields valid.
- INFO_CH_ID  out  4  channel id, header [55:52].
- INFO_TIME_STAMP  out  48  timestamp: {footer [31:8], header [51:28]}.
- INFO_BASELINE  out  12  footer [59:48].
- INFO_THRESHOLD  out  13  footer [44:32].
- INFO_FRAME_LEN  out  FRAME_LEN_WIDTH  payload word count.
- ERR_HEADER  out  1  one-cycle pulse: malformed header.
- ERR_LENGTH  out  1  one-cycle pulse: illegal length.
- ERR_FOOTER  out  1  one-cycle pulse: malformed footer.
- FRAME_CNT  out  ERR_CNT_WIDTH  good frames, saturating.
- ERR_CNT  out  ERR_CNT_WIDTH  errored frames, saturating.

Behaviour:
- Transfers: an input word is consumed when iVALID & oREADY; an output word is taken when oVALID & iREADY.
- Word formats:
  - Header valid when [63:56]=8'hFF and [27:FRAME_LEN_WIDTH]=0.
  - Footer valid when [7:0]=8'h0F, [63:60]=4'hF and [47:45]=3'b111.
- Legal length: non-zero, even, and <= MAX_FRAME_LENGTH.
- FSM states: HUNT, DATA, FOOTER.
  - HUNT: oREADY=1.
    - Consumed word is a valid header with legal length: latch ch_id, lower timestamp and length; load the remaining-word counter with length; go to DATA.
    - Valid header id but nonzero pad bits: pulse ERR_HEADER; stay in HUNT.
    - Valid header id with illegal length: pulse ERR_LENGTH; stay in HUNT.
    - Any other word: drop silently.
  - DATA: single output register stage; oREADY = ~oVALID | iREADY.
    - Each consumed word is loaded into DOUT and the counter decrements.
    - DOUT_LAST=1 on the word that brings the counter to 0; then go to FOOTER.
    - Output register holds while oVALID & ~iREADY.
  - FOOTER: oREADY=1.
    - Consumed word is a valid footer: latch fields; INFO_VALID pulses the next cycle with all INFO_*; FRAME_CNT++.
    - Otherwise: pulse ERR_FOOTER; ERR_CNT++; no INFO_VALID.
    - Either case: return to HUNT.
- Latency: payload 1 cycle from input acceptance to oVALID; INFO_VALID 1 cycle after footer acceptance.
- Header in DATA: a word matching the header pattern during DATA is treated as payload. No re-sync mid-frame; the length field is authoritative.
- Error pulses: ERR_HEADER and ERR_LENGTH also increment ERR_CNT. Pulses are mutually exclusive.
- Counters: both saturate at all-ones; no wrap.
- Simultaneous events: a header may be accepted in HUNT while the previous frame's last payload word is still held in the output register. INFO_VALID of frame k may coincide with payload of frame k+1.
- Reset, asserted at any time including mid-frame:
  - State=HUNT; oVALID=0, DOUT_LAST=0, DOUT=0.
  - INFO_VALID=0, INFO_* fields=0; all ERR_* pulses=0; FRAME_CNT=0, ERR_CNT=0.
  - oREADY=0 while RESET is asserted, then 1 in HUNT.
- The first word after reset release is treated under HUNT rules.

Decomposition:
- Package data_frame_pkg holds:
  - HEADER_ID=8'hFF and FOOTER_ID=8'h0F.
  - Field bit positions.
  - Baseline/threshold one-fill patterns.
  - State encoding for HUNT, DATA, FOOTER.
  - The same constants are reused by the frame generator.
- One sub-module, frame_stat_counter: saturating counter with increment enable, instantiated twice (FRAME_CNT, ERR_CNT).

Test Plan:
- Good frame: header 64'hFF3_123456_0000002, payload 64'hA, 64'hB, footer 64'hFABC_E123_654321_0F, iREADY=1.
  - DOUT A then B; DOUT_LAST on B.
  - Next cycle after footer: INFO_VALID with CH_ID=3, TIME_STAMP=48'h654321123456, BASELINE=12'hABC, THRESHOLD=13'h0123, FRAME_LEN=2; FRAME_CNT=1.
- Backpressure: 4-word frame with iREADY toggling 1010.
  - No lost or duplicated words; oREADY low while the output register is full and iREADY=0; order preserved.
- Bad footer: 2-word frame ending in 64'h0.
  - Payload still delivered; ERR_FOOTER pulses; ERR_CNT=1; no INFO_VALID; next good frame parses.
- Illegal lengths: headers with length 0, 3, and 401 (default MAX_FRAME_LENGTH).
  - ERR_LENGTH each time; FSM stays in HUNT; following payload-like words dropped until a valid header.
- Garbage resync: 5 random words with [63:56]!=FF, then a good frame.
  - Garbage dropped with no error pulse; frame decoded normally.
- Reset mid-frame: RESET asserted after 1 of 4 payload words.
  - All outputs zero immediately; after release, a complete new frame decodes with FRAME_CNT=1.
